// File: rtl/spm_arbiter_pkg.sv
// rtl/spm_arbiter_pkg.sv - shared strobe/direction encodings, widths and FSM states for the SPM arbiter
package spm_arbiter_pkg;

   localparam int unsigned WORD_ADDR_W = 30;
   localparam int unsigned WORD_DATA_W = 32;

   // Active-low strobe encodings
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   // Bus direction encodings
   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   // Read-return FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'h0,
      RD_IF  = 2'h1,
      RD_MEM = 2'h2
   } spm_state_e;

   // Round-robin pointer values
   typedef enum logic {
      PTR_MEM = 1'b0,
      PTR_IF  = 1'b1
   } spm_ptr_e;

   // Saturating 3-bit increment used by the starvation counter
   function automatic logic [2:0] sat_inc(input logic [2:0] cnt, input logic [2:0] lim);
      sat_inc = (cnt >= lim) ? lim : cnt + 3'd1;
   endfunction

endpackage

// File: rtl/spm_arb_pri.sv
// rtl/spm_arb_pri.sv - priority decision between fetch and data port (SPM_ARB_RR_EN selects round-robin)
module spm_arb_pri
   import spm_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic clk,
   input  logic reset_,
   input  logic if_req,
   input  logic mem_req,
   output logic if_grant,
   output logic mem_grant
);

`ifdef SPM_ARB_RR_EN

   spm_ptr_e ptr_q;
   spm_ptr_e ptr_d;

   // Pointer side wins a contested cycle, then the pointer moves to the loser
   always_comb begin
      if_grant  = if_req && (!mem_req || (ptr_q == PTR_IF));
      mem_grant = mem_req && !if_grant;
      ptr_d     = ptr_q;
      if (if_req && mem_req) begin
         ptr_d = (ptr_q == PTR_IF) ? PTR_MEM : PTR_IF;
      end
   end

   // Pointer register, starts on the data port
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         ptr_q <= PTR_MEM;
      end else begin
         ptr_q <= ptr_d;
      end
   end

`else

   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   logic [2:0] starve_cnt_q;
   logic [2:0] starve_cnt_d;

   // Data port wins unless fetch has been denied STARVE_MAX times in a row
   always_comb begin
      if_grant     = if_req && (!mem_req || (starve_cnt_q == STARVE_LIM));
      mem_grant    = mem_req && !if_grant;
      starve_cnt_d = 3'd0;
      if (if_req && !if_grant) begin
         starve_cnt_d = sat_inc(starve_cnt_q, STARVE_LIM);
      end
   end

   // Starvation counter register
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         starve_cnt_q <= 3'd0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

`endif

endmodule

// File: rtl/spm_arbiter.sv
// rtl/spm_arbiter.sv - two-port (fetch/data) arbiter onto a single SPM port; SPM_ARB_RR_EN selects round-robin
module spm_arbiter
   import spm_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic                   clk,
   input  logic                   reset_,
   input  logic                   if_as_,
   input  logic [WORD_ADDR_W-1:0] if_addr,
   output logic                   if_busy,
   output logic                   if_rdy,
   output logic [WORD_DATA_W-1:0] if_rd_data,
   input  logic                   mem_as_,
   input  logic                   mem_rw,
   input  logic [WORD_ADDR_W-1:0] mem_addr,
   input  logic [WORD_DATA_W-1:0] mem_wr_data,
   output logic                   mem_busy,
   output logic                   mem_rdy,
   output logic [WORD_DATA_W-1:0] mem_rd_data,
   output logic                   spm_as_,
   output logic                   spm_rw,
   output logic [WORD_ADDR_W-1:0] spm_addr,
   output logic [WORD_DATA_W-1:0] spm_wr_data,
   input  logic [WORD_DATA_W-1:0] spm_rd_data
);

   logic       if_req;
   logic       mem_req;
   logic       if_grant;
   logic       mem_grant;
   spm_state_e state_q;
   spm_state_e state_d;
   logic       if_rdy_q;
   logic       if_rdy_d;
   logic       mem_rdy_q;
   logic       mem_rdy_d;

   // Nothing is granted while reset is held, so the SPM port stays idle
   assign if_req  = reset_ && (if_as_ == ENABLE_);
   assign mem_req = reset_ && (mem_as_ == ENABLE_);

   spm_arb_pri #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pri (
      .clk       (clk),
      .reset_    (reset_),
      .if_req    (if_req),
      .mem_req   (mem_req),
      .if_grant  (if_grant),
      .mem_grant (mem_grant)
   );

   // Stall any strobed requester that lost arbitration this cycle
   always_comb begin
      if_busy  = (if_as_ == ENABLE_) && !if_grant;
      mem_busy = (mem_as_ == ENABLE_) && !mem_grant;
   end

   // Route the granted requester onto the SPM port; idle bus is all-default
   always_comb begin
      spm_as_     = DISABLE_;
      spm_rw      = READ;
      spm_addr    = '0;
      spm_wr_data = '0;
      if (mem_grant) begin
         spm_as_     = ENABLE_;
         spm_rw      = mem_rw;
         spm_addr    = mem_addr;
         spm_wr_data = mem_wr_data;
      end else if (if_grant) begin
         spm_as_  = ENABLE_;
         spm_addr = if_addr;
      end
   end

   // Next state: remember which port owns the read data returning next cycle
   always_comb begin
      state_d = IDLE;
      if (if_grant) begin
         state_d = RD_IF;
      end else if (mem_grant && (mem_rw == READ)) begin
         state_d = RD_MEM;
      end
      if_rdy_d  = (state_d == RD_IF);
      mem_rdy_d = (state_d == RD_MEM);
   end

   // Return FSM with registered ready flags; reset drops any outstanding read
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q   <= IDLE;
         if_rdy_q  <= 1'b0;
         mem_rdy_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         if_rdy_q  <= if_rdy_d;
         mem_rdy_q <= mem_rdy_d;
      end
   end

   // Read data passes straight through from the SPM only in the return cycle
   always_comb begin
      if_rdy      = if_rdy_q;
      mem_rdy     = mem_rdy_q;
      if_rd_data  = if_rdy_q  ? spm_rd_data : '0;
      mem_rd_data = mem_rdy_q ? spm_rd_data : '0;
   end

endmodule

// File: tb/tb_spm_arbiter.sv
// tb/tb_spm_arbiter.sv - scoreboard bench for spm_arbiter (fixed or SPM_ARB_RR_EN mode)
module tb_spm_arbiter;
   import spm_arbiter_pkg::*;

   localparam int unsigned SM = 3;

   logic        clk = 1'b0;
   logic        reset_;
   logic        if_as_;
   logic [29:0] if_addr;
   logic        if_busy, if_rdy;
   logic [31:0] if_rd_data;
   logic        mem_as_, mem_rw;
   logic [29:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic        mem_busy, mem_rdy;
   logic [31:0] mem_rd_data;
   logic        spm_as_, spm_rw;
   logic [29:0] spm_addr;
   logic [31:0] spm_wr_data;
   logic [31:0] spm_rd_data = 32'h0;

   always #5 clk = ~clk;

   spm_arbiter #(.STARVE_MAX(SM)) u_dut (
      .clk(clk), .reset_(reset_),
      .if_as_(if_as_), .if_addr(if_addr), .if_busy(if_busy), .if_rdy(if_rdy), .if_rd_data(if_rd_data),
      .mem_as_(mem_as_), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_busy(mem_busy), .mem_rdy(mem_rdy), .mem_rd_data(mem_rd_data),
      .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_addr(spm_addr), .spm_wr_data(spm_wr_data),
      .spm_rd_data(spm_rd_data)
   );

   typedef struct { logic [29:0] addr; logic rw; logic [31:0] wd; } spm_acc_t;
   typedef struct { bit is_if; logic [31:0] data; } ret_t;

   spm_acc_t    spm_q[$];
   ret_t        ret_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] model_mem[64];
   logic [31:0] spm_mem[64];
   int unsigned starve = 0;
   bit          rr_if = 1'b0;
   logic        last_if_busy, last_mem_busy, last_if_rdy, last_mem_rdy;
   logic [31:0] last_if_rd_data, last_mem_rd_data;
   bit          pend = 1'b0;
   logic [5:0]  pend_addr = 6'h0;
   spm_acc_t    e;
   ret_t        r;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: decide the winner from the arbitration rules and queue the expected bus/return traffic
   task automatic model_cycle(input bit ir, input logic [29:0] ia, input bit mr, input logic mrw,
                              input logic [29:0] ma, input logic [31:0] mwd, output bit gif, output bit gmem);
`ifdef SPM_ARB_RR_EN
      gif = ir && (!mr || rr_if);
      if (ir && mr) rr_if = !rr_if;
`else
      gif = ir && (!mr || starve == SM);
      if (ir && !gif) starve = (starve < SM) ? starve + 1 : SM;
      else starve = 0;
`endif
      gmem = mr && !gif;
      if (gif) begin
         spm_q.push_back('{ia, READ, 32'h0});
         ret_q.push_back('{1'b1, model_mem[ia[5:0]]});
      end
      if (gmem) begin
         spm_q.push_back('{ma, mrw, mwd});
         if (mrw == READ) ret_q.push_back('{1'b0, model_mem[ma[5:0]]});
         else model_mem[ma[5:0]] = mwd;
      end
   endtask

   // Called just after a rising edge; returns just after the next one
   task automatic drive_cycle(input bit ir, input logic [29:0] ia, input bit mr, input logic mrw,
                              input logic [29:0] ma, input logic [31:0] mwd, output bit gif, output bit gmem);
      if_as_      = ir ? ENABLE_ : DISABLE_;
      if_addr     = ia;
      mem_as_     = mr ? ENABLE_ : DISABLE_;
      mem_rw      = mrw;
      mem_addr    = ma;
      mem_wr_data = mwd;
      model_cycle(ir, ia, mr, mrw, ma, mwd, gif, gmem);
      @(negedge clk);
      last_if_busy     = if_busy;
      last_mem_busy    = mem_busy;
      last_if_rdy      = if_rdy;
      last_mem_rdy     = mem_rdy;
      last_if_rd_data  = if_rd_data;
      last_mem_rd_data = mem_rd_data;
      chk("if_busy", {31'h0, if_busy}, {31'h0, ir && !gif});
      chk("mem_busy", {31'h0, mem_busy}, {31'h0, mr && !gmem});
      @(posedge clk);
      #1;
   endtask

   // SPM stub returns the addressed word on the edge after a granted read
   always @(posedge clk) begin
      spm_rd_data = pend ? spm_mem[pend_addr] : $urandom();
   end

   // Monitor: compare SPM bus traffic and read returns against the scoreboard
   always @(negedge clk) begin
      if (spm_as_ === ENABLE_) begin
         if (spm_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL spm_unexpected: got access addr %h expected none at %0t", spm_addr, $time);
         end else begin
            e = spm_q.pop_front();
            chk("spm_addr", {2'b0, spm_addr}, {2'b0, e.addr});
            chk("spm_rw", {31'h0, spm_rw}, {31'h0, e.rw});
            chk("spm_wr_data", spm_wr_data, e.wd);
         end
         if (spm_rw == WRITE) spm_mem[spm_addr[5:0]] = spm_wr_data;
         pend      = (spm_rw == READ);
         pend_addr = spm_addr[5:0];
      end else begin
         chk("spm_idle_bus", {spm_addr, spm_rw, spm_as_}, {30'h0, READ, DISABLE_});
         chk("spm_idle_wd", spm_wr_data, 32'h0);
         pend = 1'b0;
      end
      chk("rdy_exclusive", {31'h0, if_rdy && mem_rdy}, 32'h0);
      if (if_rdy === 1'b1) begin
         if (ret_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL if_rdy_unexpected: got rdy 1 expected 0 at %0t", $time);
         end else begin
            r = ret_q.pop_front();
            chk("if_rdy_port", {31'h0, r.is_if}, 32'h1);
            chk("if_rd_data", if_rd_data, r.data);
         end
      end else begin
         chk("if_rd_data_idle", if_rd_data, 32'h0);
      end
      if (mem_rdy === 1'b1) begin
         if (ret_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL mem_rdy_unexpected: got rdy 1 expected 0 at %0t", $time);
         end else begin
            r = ret_q.pop_front();
            chk("mem_rdy_port", {31'h0, r.is_if}, 32'h0);
            chk("mem_rd_data", mem_rd_data, r.data);
         end
      end else begin
         chk("mem_rd_data_idle", mem_rd_data, 32'h0);
      end
      chk("ret_pending", {31'h0, ret_q.size() <= 1}, 32'h1);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog expired");
   end

   bit          gi, gm;
   bit          ih, mh, mrw_h;
   logic [29:0] ia_h, ma_h;
   logic [31:0] mwd_h;
`ifdef SPM_ARB_RR_EN
   bit exp_ifb[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
   bit exp_ifb[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif

   initial begin
      for (int i = 0; i < 64; i++) begin
         model_mem[i] = $urandom();
         spm_mem[i]   = model_mem[i];
      end
      model_mem[16] = 32'hDEADBEEF;
      spm_mem[16]   = 32'hDEADBEEF;

      reset_ = 1'b0; if_as_ = DISABLE_; mem_as_ = DISABLE_; mem_rw = READ;
      if_addr = '0; mem_addr = '0; mem_wr_data = '0;
      @(negedge clk);
      chk("rst_rdy", {30'h0, if_rdy, mem_rdy}, 32'h0);
      chk("rst_busy", {30'h0, if_busy, mem_busy}, 32'h0);
      chk("rst_spm_as", {31'h0, spm_as_}, {31'h0, DISABLE_});
      chk("rst_if_rd_data", if_rd_data, 32'h0);
      @(posedge clk); #1;
      reset_ = 1'b1;

      // Both ports requesting continuously: fixed priority starves fetch for SM cycles, RR alternates
      for (int c = 0; c < 5; c++) begin
         drive_cycle(1'b1, 30'h10, 1'b1, READ, 30'h20, 32'h0, gi, gm);
         chk("contend_if_busy", {31'h0, last_if_busy}, {31'h0, exp_ifb[c]});
         chk("contend_mem_busy", {31'h0, last_mem_busy}, {31'h0, !exp_ifb[c]});
      end
      drive_cycle(1'b0, 30'h0, 1'b0, READ, 30'h0, 32'h0, gi, gm);
      drive_cycle(1'b0, 30'h0, 1'b0, READ, 30'h0, 32'h0, gi, gm);

      // Fetch-only read returns the SPM word next cycle
      drive_cycle(1'b1, 30'h10, 1'b0, READ, 30'h0, 32'h0, gi, gm);
      chk("fetch_only_busy", {31'h0, last_if_busy}, 32'h0);
      drive_cycle(1'b0, 30'h0, 1'b0, READ, 30'h0, 32'h0, gi, gm);
      chk("fetch_only_rdy", {31'h0, last_if_rdy}, 32'h1);
      chk("fetch_only_data", last_if_rd_data, 32'hDEADBEEF);

      // Data write completes in the grant cycle with no ready pulse
      drive_cycle(1'b0, 30'h0, 1'b1, WRITE, 30'h40, 32'h12345678, gi, gm);
      drive_cycle(1'b0, 30'h0, 1'b0, READ, 30'h0, 32'h0, gi, gm);
      chk("write_no_rdy", {31'h0, last_mem_rdy}, 32'h0);

      // Back-to-back data reads return on consecutive cycles
      drive_cycle(1'b0, 30'h0, 1'b1, READ, 30'h1, 32'h0, gi, gm);
      drive_cycle(1'b0, 30'h0, 1'b1, READ, 30'h2, 32'h0, gi, gm);
      chk("b2b_rdy1", {31'h0, last_mem_rdy}, 32'h1);
      chk("b2b_data1", last_mem_rd_data, model_mem[1]);
      drive_cycle(1'b0, 30'h0, 1'b0, READ, 30'h0, 32'h0, gi, gm);
      chk("b2b_rdy2", {31'h0, last_mem_rdy}, 32'h1);
      chk("b2b_data2", last_mem_rd_data, model_mem[2]);

      // Random traffic; a busy requester holds its request unchanged
      ih = 1'b0; mh = 1'b0; ia_h = '0; ma_h = '0; mrw_h = READ; mwd_h = '0;
      for (int c = 0; c < 400; c++) begin
         if (!ih) begin
            ih   = ($urandom_range(0, 9) < 6);
            ia_h = 30'($urandom());
         end
         if (!mh) begin
            mh    = ($urandom_range(0, 9) < 6);
            ma_h  = 30'($urandom());
            mrw_h = $urandom_range(0, 1) == 1 ? READ : WRITE;
            mwd_h = $urandom();
         end
         drive_cycle(ih, ia_h, mh, mrw_h, ma_h, mwd_h, gi, gm);
         ih = ih && !gi;
         mh = mh && !gm;
      end
      drive_cycle(1'b0, 30'h0, 1'b0, READ, 30'h0, 32'h0, gi, gm);

      // Reset while a fetch read is outstanding: the read is dropped
      if_as_ = ENABLE_; if_addr = 30'h10; mem_as_ = DISABLE_;
      model_cycle(1'b1, 30'h10, 1'b0, READ, 30'h0, 32'h0, gi, gm);
      @(negedge clk); #2;
      reset_ = 1'b0;
      if_as_ = DISABLE_;
      ret_q.delete();
      starve = 0;
      rr_if  = 1'b0;
      @(posedge clk); #1;
      if_as_ = ENABLE_;
      @(negedge clk);
      chk("rst_hold_if_rdy", {31'h0, if_rdy}, 32'h0);
      chk("rst_hold_if_busy", {31'h0, if_busy}, 32'h1);
      chk("rst_hold_spm_as", {31'h0, spm_as_}, {31'h0, DISABLE_});
      @(posedge clk); #1;
      if_as_ = DISABLE_;
      @(negedge clk);
      chk("rst_hold2_if_rdy", {31'h0, if_rdy}, 32'h0);
      @(posedge clk); #1;
      reset_ = 1'b1;
      for (int c = 0; c < 2; c++) begin
         drive_cycle(1'b0, 30'h0, 1'b0, READ, 30'h0, 32'h0, gi, gm);
         chk("post_rst_if_rdy", {31'h0, last_if_rdy}, 32'h0);
      end

      chk("spm_q_drained", spm_q.size(), 32'h0);
      chk("ret_q_drained", ret_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spm_arbiter.md
SPM_ARBITER -- requirements
Module: spm_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3, means the consecutive fetch denials after which fetch wins one arbitration (range 1..7).
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset_  in  1  asynchronous, active-low reset.
REQ-004 if_as_  in  1  fetch address strobe, active-low; fetch is read-only.
REQ-005 if_addr  in  30  fetch word address.
REQ-006 if_busy  out  1  fetch request present but not granted this cycle (stall).
REQ-007 if_rdy  out  1  fetch read data valid.
REQ-008 if_rd_data  out  32  fetch read data.
REQ-009 mem_as_  in  1  data-port address strobe, active-low.
REQ-010 mem_rw  in  1  data-port direction, READ/WRITE encoding from stddef.h.
REQ-011 mem_addr  in  30  data-port word address.
REQ-012 mem_wr_data  in  32  data-port write data.
REQ-013 mem_busy  out  1  data request present but not granted this cycle.
REQ-014 mem_rdy  out  1  data read data valid.
REQ-015 mem_rd_data  out  32  data-port read data.
REQ-016 spm_as_ / spm_rw / spm_addr / spm_wr_data  out  1/1/30/32  single SPM port.
REQ-017 spm_rd_data  in  32  SPM read data, valid one cycle after a granted read.

Function
REQ-018 At most one requester SHALL be granted per cycle; grant is combinational from current requests and state.
REQ-019 Granted port's addr/rw/wr_data SHALL drive spm_* with spm_as_ = ENABLE_; fetch grants drive spm_rw = READ, spm_wr_data = 0.
REQ-020 No grant: spm_as_ = DISABLE_, spm_addr = 0, spm_rw = READ, spm_wr_data = 0.
REQ-021 Busy SHALL equal "strobe asserted and not granted"; a requester holds its request stable while busy.
REQ-022 FSM states IDLE, RD_IF, RD_MEM; next state RD_IF after granted fetch read, RD_MEM after granted data read, IDLE otherwise (including granted writes).
REQ-023 In RD_IF: if_rdy = 1, if_rd_data = spm_rd_data; in RD_MEM: mem_rdy = 1, mem_rd_data = spm_rd_data; otherwise rdy = 0 and rd_data = 32'h0.
REQ-024 Read latency: rdy exactly one cycle after grant; writes complete in the grant cycle with no rdy pulse.
REQ-025 Grant and return SHALL overlap: a new grant is legal in RD_IF/RD_MEM (back-to-back reads, one per cycle).
REQ-026 Default policy: data port has priority over fetch when both request.
REQ-027 Starvation counter (3 bits): +1 each cycle fetch is busy; cleared when fetch granted or fetch not requesting; saturates at STARVE_MAX.
REQ-028 Counter == STARVE_MAX and both request: fetch SHALL be granted, data port busy.
REQ-029 Single requester: granted immediately regardless of counter or pointer.

Reset
REQ-030 reset_ low: state IDLE, counter 0, priority pointer to data port, all rdy 0, rd_data 0, spm_as_ DISABLE_, busy follows REQ-021 combinationally.
REQ-031 Reset asserted with a read outstanding: the read is discarded; no rdy after reset release.

Configuration
REQ-032 Macro SPM_ARB_RR_EN defined: round-robin; 1-bit pointer toggles to the other port after each cycle in which both request; starvation counter and STARVE_MAX unused.
REQ-033 SPM_ARB_RR_EN undefined: fixed data priority with starvation counter (REQ-026..028).

Structure
REQ-034 ENABLE_/DISABLE_, READ/WRITE, word-address width (30) and data width (32) come from shared headers stddef.h/cpu.h; FSM state encodings (2 bits) are added to cpu.h.
REQ-035 One sub-module, spm_arb_pri, holds the priority decision (counter or RR pointer) and outputs the grant; the top holds the FSM and muxes.

Verification
REQ-036 Fetch only, if_addr=30'h10, spm_rd_data=32'hDEADBEEF next cycle -> spm_as_ low at cycle 0, if_rdy=1 and if_rd_data=32'hDEADBEEF at cycle 1, if_busy=0.
REQ-037 Both request continuously, data read 30'h20, STARVE_MAX=3, fixed mode -> data granted cycles 0-2, if_busy=1 cycles 0-2, fetch granted cycle 3, counter 0 at cycle 4.
REQ-038 Data write 30'h40 wr_data 32'h12345678 -> spm_rw=WRITE, spm_wr_data=32'h12345678 same cycle, mem_rdy stays 0, state IDLE.
REQ-039 SPM_ARB_RR_EN, both request 4 cycles -> grants alternate mem, if, mem, if.
REQ-040 Fetch read granted, reset_ asserted before next edge, released 2 cycles later -> if_rdy never 1, outputs at reset values.
REQ-041 Back-to-back data reads 30'h1, 30'h2 -> mem_rdy=1 cycles 1 and 2 with matching SPM data each cycle.
